valid_scatter32: RTL

- Inverse of the 32-lane valid OR-reduction: takes one aggregated 32-bit valid mask and scatters each set bit into exactly one of 32 lane slices of a 1024-bit vector.
- Lane choice is round-robin and skips busy lanes. OR-reducing the output slices therefore reproduces the input mask exactly.
- Sits upstream of the per-lane engines in the max16 datapath, feeding their valid inputs; its output is consumed by the existing 1024-to-32 valid reducer for consistency checks.

---
 rtl/valid_scatter32.sv | 105 ++++++++++
 1 files changed

// File: rtl/valid_scatter32.sv
// valid_scatter32: scatters an aggregated 32-bit valid mask into 32 lane slices,
// one bit per cycle, choosing lanes round-robin and skipping busy lanes.
module valid_scatter32 #(
  parameter int       NLANE    = 32,
  parameter int       VW       = 32,
  parameter bit [4:0] PTR_INIT = 5'd0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [VW-1:0]         in_mask,
  input  logic [NLANE-1:0]      lane_busy,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [NLANE*VW-1:0]   dout,
  output logic [4:0]            rr_ptr
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [31:0] pending;
  logic [4:0]  bit_idx;
  logic [4:0]  off;
  logic [4:0]  lane;
  logic [63:0] busy_dbl;
  logic [31:0] busy_rot;
  logic        free;
  logic        place;
  logic        last;
  logic        accept;
  logic        drain;

  always_comb begin
    bit_idx = '0;
    for (int i = 31; i >= 0; i--)
      if (pending[i]) bit_idx = 5'(i);
  end

  // rotate so bit 0 is the lane at rr_ptr; first zero is the offset
  assign busy_dbl = {lane_busy, lane_busy} >> rr_ptr;
  assign busy_rot = busy_dbl[31:0];

  always_comb begin
    off = '0;
    for (int i = 31; i >= 0; i--)
      if (!busy_rot[i]) off = 5'(i);
  end

  assign lane   = rr_ptr + off;
  assign free   = ~&lane_busy;
  assign accept = in_valid & in_ready;
  assign place  = (state == SCAN) & free & (|pending);
  assign last   = (pending & ~(32'd1 << bit_idx)) == 32'd0;
  assign drain  = (state == DONE) & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (accept) state_nx = (|in_mask) ? SCAN : DONE;
      SCAN: if (place && last) state_nx = DONE;
      DONE: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      dout    <= '0;
      rr_ptr  <= PTR_INIT;
    end else begin
      unique case (1'b1)
        accept: begin
          pending <= in_mask;
          dout    <= '0;
        end
        place: begin
          dout[{lane, bit_idx}] <= 1'b1;
          pending[bit_idx]      <= 1'b0;
          rr_ptr                <= lane + 5'd1;
        end
        drain: dout <= '0;
        default: ;
      endcase
    end
  end

endmodule
